// File: rtl/sobel_edge_core.sv
// Sobel edge magnitude on a streamed 3x3 window, border pixels forced to zero, 3-cycle latency.
// Optional macro SOBEL_BINARY_EN turns the clamped magnitude into a thresholded binary edge map.
module sobel_edge_core #(
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480
) (
  input  logic        InClk,
  input  logic        InRstN,
  input  logic        InFrameStart,
  input  logic        InMatrixDe,
  input  logic [23:0] InMatrixData1,
  input  logic [23:0] InMatrixData2,
  input  logic [23:0] InMatrixData3,
  input  logic [7:0]  InThreshold,
  output logic [7:0]  OutData,
  output logic        OutDe
);

  localparam int CW = (IMAGE_W > 4) ? $clog2(IMAGE_W) : 2;
  localparam int RW = (IMAGE_H > 4) ? $clog2(IMAGE_H) : 2;
  localparam logic [CW-1:0] COL_MAX = CW'(IMAGE_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMAGE_H - 1);

  logic [CW-1:0] colCntReg;
  logic [RW-1:0] rowCntReg;
  logic          prevDeReg;

  // pix[R][C]: R=1..3 top..bottom, C=1..3 left..right
  logic [7:0] pix [1:3][1:3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gUnpack
      assign pix[1][gi+1] = InMatrixData1[23-8*gi -: 8];
      assign pix[2][gi+1] = InMatrixData2[23-8*gi -: 8];
      assign pix[3][gi+1] = InMatrixData3[23-8*gi -: 8];
    end
  endgenerate

  function automatic logic [9:0] sum121(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [9:0] absDiff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic windowValid;
  assign windowValid = InMatrixDe && (colCntReg >= CW'(2)) && (rowCntReg >= RW'(2));

  logic [9:0] sumAReg, sumBReg, sumCReg, sumDReg;
  logic       de1Reg, valid1Reg;
  logic [9:0] absGxReg, absGyReg;
  logic       de2Reg, valid2Reg;

  logic [10:0] magNext;
  logic [7:0]  pixNext;
  assign magNext = {1'b0, absGxReg} + {1'b0, absGyReg};

`ifdef SOBEL_BINARY_EN
  assign pixNext = (magNext >= {3'b000, InThreshold}) ? 8'd255 : 8'd0;
`else
  assign pixNext = (magNext > 11'd255) ? 8'd255 : magNext[7:0];
  logic unusedThreshold;
  assign unusedThreshold = ^InThreshold;
`endif

  always_ff @(posedge InClk) begin
    if (!InRstN) begin
      colCntReg <= '0;
      rowCntReg <= '0;
      prevDeReg <= 1'b0;
      sumAReg   <= '0;
      sumBReg   <= '0;
      sumCReg   <= '0;
      sumDReg   <= '0;
      de1Reg    <= 1'b0;
      valid1Reg <= 1'b0;
      absGxReg  <= '0;
      absGyReg  <= '0;
      de2Reg    <= 1'b0;
      valid2Reg <= 1'b0;
      OutData   <= '0;
      OutDe     <= 1'b0;
    end else begin
      prevDeReg <= InMatrixDe;
      if (!InMatrixDe)
        colCntReg <= '0;
      else if (colCntReg != COL_MAX)
        colCntReg <= colCntReg + 1'b1;

      // Frame start wins over a line ending in the same cycle
      if (InFrameStart)
        rowCntReg <= '0;
      else if (prevDeReg && !InMatrixDe && (rowCntReg != ROW_MAX))
        rowCntReg <= rowCntReg + 1'b1;

      sumAReg   <= sum121(pix[1][3], pix[2][3], pix[3][3]);
      sumBReg   <= sum121(pix[1][1], pix[2][1], pix[3][1]);
      sumCReg   <= sum121(pix[3][1], pix[3][2], pix[3][3]);
      sumDReg   <= sum121(pix[1][1], pix[1][2], pix[1][3]);
      de1Reg    <= InMatrixDe;
      valid1Reg <= windowValid;

      absGxReg  <= absDiff(sumAReg, sumBReg);
      absGyReg  <= absDiff(sumCReg, sumDReg);
      de2Reg    <= de1Reg;
      valid2Reg <= valid1Reg;

      OutDe     <= de2Reg;
      OutData   <= (de2Reg && valid2Reg) ? pixNext : 8'd0;
    end
  end

endmodule

// File: tb/tb_sobel_edge_core.sv
// Directed bench for sobel_edge_core: hand-computed windows, border zeroing, frame start and reset.
// Small IMAGE_W/IMAGE_H so column and row saturation are reached with short lines.
module tb_sobel_edge_core;

  localparam int LINE_LEN = 8;

  logic        InClk = 1'b0;
  logic        InRstN;
  logic        InFrameStart;
  logic        InMatrixDe;
  logic [23:0] InMatrixData1, InMatrixData2, InMatrixData3;
  logic [7:0]  InThreshold;
  logic [7:0]  OutData;
  logic        OutDe;

  int compared   = 0;
  int mismatched = 0;
  int stepIdx    = 0;
  int lineIdx    = 0;

  logic       histDe   [0:2047];
  logic [7:0] histData [0:2047];

  localparam int K_FLAT = 0, K_VEDGE = 1, K_MIRROR = 2, K_HSTEP = 3;

  sobel_edge_core #(.IMAGE_W(6), .IMAGE_H(8)) dut (
    .InClk(InClk), .InRstN(InRstN), .InFrameStart(InFrameStart),
    .InMatrixDe(InMatrixDe), .InMatrixData1(InMatrixData1),
    .InMatrixData2(InMatrixData2), .InMatrixData3(InMatrixData3),
    .InThreshold(InThreshold), .OutData(OutData), .OutDe(OutDe)
  );

  always #5 InClk = ~InClk;

  task automatic checkVal(input string tag, input int obs, input int exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Rows of each test window, top to bottom
  function automatic logic [23:0] winRow(input int kind, input int r);
    case (kind)
      K_FLAT:   return 24'h646464;
      K_VEDGE:  return 24'h00FFFF;
      K_MIRROR: return 24'hFFFF00;
      default:  return (r == 1) ? 24'h0A0A0A : 24'h141414;
    endcase
  endfunction

  // Hand-computed result for an interior window of each kind
  function automatic logic [7:0] expOf(input int kind);
`ifdef SOBEL_BINARY_EN
    case (kind)
      K_FLAT:  return (InThreshold == 8'd0) ? 8'd255 : 8'd0;
      K_HSTEP: return (InThreshold <= 8'd40) ? 8'd255 : 8'd0;
      default: return 8'd255;
    endcase
`else
    case (kind)
      K_FLAT:  return 8'd0;
      K_HSTEP: return 8'd40;
      default: return 8'd255;
    endcase
`endif
  endfunction

  task automatic step(input logic rstN, input logic fs, input logic de,
                      input int kind, input logic [7:0] expD);
    int ei;
    InRstN        = rstN;
    InFrameStart  = fs;
    InMatrixDe    = de;
    InMatrixData1 = winRow(kind, 1);
    InMatrixData2 = winRow(kind, 2);
    InMatrixData3 = winRow(kind, 3);
    histDe[stepIdx]   = de;
    histData[stepIdx] = de ? expD : 8'd0;
    if (!rstN) begin
      for (int k = 0; k < 3; k++)
        if (stepIdx - k >= 0) begin
          histDe[stepIdx-k]   = 1'b0;
          histData[stepIdx-k] = 8'd0;
        end
    end
    @(posedge InClk);
    #1;
    ei = stepIdx - 2;
    checkVal($sformatf("de@%0d", stepIdx), int'(OutDe), (ei >= 0) ? int'(histDe[ei]) : 0);
    checkVal($sformatf("data@%0d", stepIdx), int'(OutData), (ei >= 0) ? int'(histData[ei]) : 0);
    stepIdx++;
  endtask

  task automatic gap(input int n, input logic fsFirst);
    for (int i = 0; i < n; i++)
      step(1'b1, (i == 0) ? fsFirst : 1'b0, 1'b0, K_FLAT, 8'd0);
  endtask

  task automatic line(input int kind, input logic rowValid);
    for (int c = 0; c < LINE_LEN; c++)
      step(1'b1, 1'b0, 1'b1, kind, (rowValid && c >= 2) ? expOf(kind) : 8'd0);
    $display("line %0d kind %0d rowValid %0d step %0d", lineIdx, kind, rowValid, stepIdx);
    lineIdx++;
  endtask

  initial begin
    InRstN = 1'b0; InFrameStart = 1'b0; InMatrixDe = 1'b0;
    InMatrixData1 = '0; InMatrixData2 = '0; InMatrixData3 = '0;
    InThreshold = 8'd50;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, K_FLAT, 8'd0);
    gap(2, 1'b1);

    line(K_VEDGE, 1'b0); gap(1, 1'b0);
    line(K_VEDGE, 1'b0); gap(1, 1'b0);
    line(K_VEDGE, 1'b1); gap(1, 1'b0);
    line(K_HSTEP, 1'b1); gap(2, 1'b0);
    line(K_FLAT,  1'b1); gap(1, 1'b0);
    line(K_MIRROR, 1'b1); gap(1, 1'b0);
    InThreshold = 8'd40;
    line(K_HSTEP, 1'b1); gap(3, 1'b0);
    InThreshold = 8'd50;
    line(K_VEDGE, 1'b1); gap(1, 1'b0);
    line(K_VEDGE, 1'b1);

    // Frame start lands on the line's falling edge
    gap(2, 1'b1);
    line(K_VEDGE, 1'b0); gap(1, 1'b0);
    line(K_VEDGE, 1'b0); gap(1, 1'b0);
    line(K_VEDGE, 1'b1); gap(1, 1'b0);

    // Reset in the middle of a valid line; counters must restart at row 0
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b1, K_VEDGE, (c >= 2) ? 8'd255 : 8'd0);
    step(1'b0, 1'b0, 1'b1, K_VEDGE, 8'd0);
    step(1'b0, 1'b0, 1'b1, K_VEDGE, 8'd0);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b1, K_VEDGE, 8'd0);
    $display("line %0d reset mid-line step %0d", lineIdx, stepIdx);
    lineIdx++;
    gap(1, 1'b0);
    line(K_VEDGE, 1'b0); gap(1, 1'b0);
    line(K_VEDGE, 1'b1); gap(4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
